alu_exec_unit: RTL

- Multi-cycle execute stage that takes the 3-bit ALU control code from the ALU decoder, plus the two operands, and produces a registered result and zero flag.
- Logic/arithmetic ops finish in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle.
- Valid/ready handshakes on both sides let it sit between decode and writeback/branch resolution, and let the control unit stall on long shifts.

---
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle logic/arithmetic, iterative shifts,
// valid/ready handshakes on both the request and result sides.
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUControl_i,
    input  logic [WIDTH-1:0] SrcA_i,
    input  logic [WIDTH-1:0] SrcB_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] STEP_MAX = (SHW + 1)'(SHIFT_STEP);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SRL = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_ILL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             left_q, left_d;
    logic [SHW-1:0]   rem_q, rem_d;

    alu_op_e          op;
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   amount;
    logic [SHW:0]     step;
    logic [WIDTH-1:0] alu_res;

    assign op       = alu_op_e'(ALUControl_i);
    assign amount   = SrcB_i[SHW-1:0];
    assign is_shift = (op == OP_SLL) || (op == OP_SRL);
    // Combinational on ready_i so a new request can enter in the cycle the result drains.
    assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept   = valid_i && ready_o;
    assign step     = (int'(rem_q) < SHIFT_STEP) ? {1'b0, rem_q} : STEP_MAX;

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = SrcA_i + SrcB_i;
            OP_SUB:  alu_res = SrcA_i - SrcB_i;
            OP_AND:  alu_res = SrcA_i & SrcB_i;
            OP_OR:   alu_res = SrcA_i | SrcB_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA_i) < $signed(SrcB_i))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        left_d    = left_q;
        rem_d     = rem_q;

        case (state_q)
            SHIFT: begin
                result_d = left_q ? (result_q << step) : (result_q >> step);
                rem_d    = rem_q - step[SHW-1:0];
                zero_d   = (result_d == '0);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i && !valid_i) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // The working register doubles as the result register while shifting.
        if (accept) begin
            illegal_d = (op == OP_ILL);
            left_d    = (op == OP_SLL);
            rem_d     = '0;
            if (is_shift) begin
                result_d = SrcA_i;
                rem_d    = amount;
                state_d  = (amount == '0) ? DONE : SHIFT;
            end else begin
                result_d = alu_res;
                state_d  = DONE;
            end
            zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            left_q    <= 1'b0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            left_q    <= left_d;
            rem_q     <= rem_d;
        end
    end

    assign valid_o   = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule
